// File: rtl/math_pkg.sv
// Shared definitions for the math datapath blocks (GCD, LCM): FSM state encoding
// and the double-width helper used for product/result buses.
package math_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_GCD  = 3'd1,
    S_DIV  = 3'd2,
    S_MUL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic int dbl_w(input int w);
    return 2 * w;
  endfunction

endpackage

// File: rtl/lcm_euclid_step.sv
// One subtraction-based Euclid step: the larger operand is reduced by the smaller.
// Purely combinational; the compare selects the subtraction, so neither side underflows.
module lcm_euclid_step #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic [n-1:0] a_nxt,
  output logic [n-1:0] b_nxt,
  output logic         eq
);

  always_comb begin
    eq    = (a == b);
    a_nxt = a;
    b_nxt = b;
    if (a > b) begin
      a_nxt = a - b;
    end else if (b > a) begin
      b_nxt = b - a;
    end
  end

endmodule

// File: rtl/lcm_using_fsm.sv
// Sequential LCM(x,y) = (x / GCD) * y via Euclid subtraction, restoring divide and shift-add multiply.
// Optional LCM_CYCLE_CNT_EN adds cyc_cnt, a saturating count of busy cycles per job.
module lcm_using_fsm
  import math_pkg::*;
#(
  parameter int n = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [n-1:0]        x,
  input  logic [n-1:0]        y,
  output logic                busy,
  output logic                done,
  output logic [dbl_w(n)-1:0] lcm,
  output logic                err
`ifdef LCM_CYCLE_CNT_EN
  ,
  output logic [15:0]         cyc_cnt
`endif
);

  localparam int w2 = dbl_w(n);
  localparam int cw = $clog2(n + 1);
  localparam logic [cw-1:0] last_step = cw'(n - 1);

  state_t state, state_nxt;

  logic [n-1:0]  a, b, x_hold, y_hold, g, dq;
  logic [n:0]    rem;
  logic [w2-1:0] acc, mcand;
  logic [cw-1:0] step;
  logic          zero;

  logic [n-1:0]  a_nxt, b_nxt;
  logic          eq;
  logic          accept, in_zero, step_last, q_bit;
  logic [n:0]    rem_sh, rem_sub;
  logic [w2-1:0] acc_nxt;

  lcm_euclid_step #(.n(n)) u_euclid_step (
    .a     (a),
    .b     (b),
    .a_nxt (a_nxt),
    .b_nxt (b_nxt),
    .eq    (eq)
  );

  always_comb begin
    accept    = (state == S_IDLE) && start;
    in_zero   = (x == '0) || (y == '0);
    step_last = (step == last_step);
    rem_sh    = {rem[n-1:0], dq[n-1]};
    q_bit     = (rem_sh >= {1'b0, g});
    rem_sub   = q_bit ? (rem_sh - {1'b0, g}) : rem_sh;
    acc_nxt   = dq[0] ? (acc + mcand) : acc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = in_zero ? S_DONE : S_GCD;
      S_GCD:  if (eq) state_nxt = S_DIV;
      S_DIV:  if (step_last) state_nxt = S_MUL;
      S_MUL:  if (step_last) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // dq holds the dividend while dividing, then the quotient doubles as the multiplier.
  // lcm/err load on the edge into S_DONE so they are valid alongside the done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a      <= '0;
      b      <= '0;
      x_hold <= '0;
      y_hold <= '0;
      g      <= '0;
      dq     <= '0;
      rem    <= '0;
      acc    <= '0;
      mcand  <= '0;
      step   <= '0;
      zero   <= 1'b0;
      lcm    <= '0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a      <= x;
            b      <= y;
            x_hold <= x;
            y_hold <= y;
            zero   <= in_zero;
            acc    <= '0;
            step   <= '0;
            if (in_zero) begin
              lcm <= '0;
              err <= 1'b1;
            end
          end
        end
        S_GCD: begin
          if (eq) begin
            g     <= a;
            dq    <= x_hold;
            rem   <= '0;
            mcand <= {{n{1'b0}}, y_hold};
            step  <= '0;
          end else begin
            a <= a_nxt;
            b <= b_nxt;
          end
        end
        S_DIV: begin
          dq   <= {dq[n-2:0], q_bit};
          rem  <= rem_sub;
          step <= step_last ? '0 : step + 1'b1;
        end
        S_MUL: begin
          acc   <= acc_nxt;
          mcand <= mcand << 1;
          dq    <= dq >> 1;
          step  <= step_last ? '0 : step + 1'b1;
          if (step_last) begin
            lcm <= acc_nxt;
            err <= zero;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef LCM_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_cnt <= '0;
    end else if (accept) begin
      cyc_cnt <= '0;
    end else if (busy && (cyc_cnt != 16'hFFFF)) begin
      cyc_cnt <= cyc_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lcm_using_fsm.sv
// Directed and swept self-checking bench for lcm_using_fsm (n = 8).
module tb_lcm_using_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  x, y;
  logic        busy, done, err;
  logic [15:0] lcm;
`ifdef LCM_CYCLE_CNT_EN
  logic [15:0] cyc_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  lcm_using_fsm #(.n(8)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .x     (x),
    .y     (y),
    .busy  (busy),
    .done  (done),
    .lcm   (lcm),
    .err   (err)
`ifdef LCM_CYCLE_CNT_EN
    ,
    .cyc_cnt (cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int gcd_ref(input int p, input int q);
    int t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  // Euclid subtraction steps plus the final equality cycle.
  function automatic int gcd_cycles(input int p, input int q);
    int k = 1;
    while (p != q) begin
      if (p > q) p = p - q; else q = q - p;
      k++;
    end
    return k;
  endfunction

  // Called one step after a rising edge with the DUT idle; returns one step after
  // the edge following done, so the DUT is idle again. lat counts edges from the
  // accepting edge (inclusive) to the edge that raises done.
  task automatic run_job(input string tag, input logic [7:0] xa, input logic [7:0] ya,
                         output int lat, output int busy_cyc);
    x = xa;
    y = ya;
    start = 1'b1;
    busy_cyc = 0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 2000) begin
      if (busy) busy_cyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (busy) busy_cyc++;
    if (!done) check({tag, "_timeout"}, 0, 1);
    @(posedge clk); #1;
`ifdef LCM_CYCLE_CNT_EN
    check({tag, "_cyc_cnt"}, cyc_cnt, lat);
`endif
  endtask

  initial begin
    int lat, bc, dn;
    reset = 1'b1;
    start = 1'b0;
    x = '0;
    y = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_lcm", lcm, 0);
    check("rst_err", err, 0);
`ifdef LCM_CYCLE_CNT_EN
    check("rst_cyc_cnt", cyc_cnt, 0);
`endif
    reset = 1'b0;
    @(posedge clk); #1;

    // 12,18: (12,18)->(12,6)->(6,6)->eq, k=3
    run_job("j12_18", 8'd12, 8'd18, lat, bc);
    check("j12_18_lcm", lcm, 36);
    check("j12_18_err", err, 0);
    check("j12_18_lat", lat, 20);

    // gcd 1: one a-step, 253 b-steps, eq cycle -> k=255
    run_job("j255_254", 8'd255, 8'd254, lat, bc);
    check("j255_254_lcm", lcm, 16'hFD02);
    check("j255_254_err", err, 0);
    check("j255_254_lat", lat, 272);

    run_job("j7_7", 8'd7, 8'd7, lat, bc);
    check("j7_7_lcm", lcm, 7);
    check("j7_7_lat", lat, 18);

    run_job("j0_5", 8'd0, 8'd5, lat, bc);
    check("j0_5_lcm", lcm, 0);
    check("j0_5_err", err, 1);
    check("j0_5_lat", lat, 1);
    check("j0_5_busy_cycles", bc, 1);

    // start held high: one done, then re-accepted right after the idle cycle
    x = 8'd9;
    y = 8'd6;
    start = 1'b1;
    dn = 0;
    @(posedge clk); #1;
    lat = 1;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_lat", lat, 20);
    check("hold_lcm", lcm, 18);
    @(posedge clk); #1;
    check("hold_idle_busy", busy, 0);
    check("hold_idle_done", done, 0);
    @(posedge clk); #1;
    check("hold_reaccept_busy", busy, 1);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    check("hold_second_lcm", lcm, 18);
    @(posedge clk); #1;

    // reset in the middle of S_DIV (entered after 4 edges for 12,18)
    x = 8'd12;
    y = 8'd18;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
    end
    check("mid_busy", busy, 1);
    reset = 1'b1;
    #2;
    check("abort_busy", busy, 0);
    check("abort_lcm", lcm, 0);
    check("abort_err", err, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    check("abort_no_done", dn, 0);
    run_job("j4_6", 8'd4, 8'd6, lat, bc);
    check("j4_6_lcm", lcm, 12);

    for (int i = 1; i <= 31; i++) begin
      for (int j = 1; j <= 31; j++) begin
        run_job("sweep", 8'(i), 8'(j), lat, bc);
        check("sweep_lcm", lcm, (i / gcd_ref(i, j)) * j);
        check("sweep_err", err, 0);
        check("sweep_lat", lat, 1 + gcd_cycles(i, j) + 16);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
